// File: rtl/bcd_display_scan_if.sv
// Purpose: bundles the stopwatch digit inputs, display controls and display pin outputs.
// Latency: none, wires only.
// Backpressure: none; the display free-runs and never stalls the timer.
interface bcd_display_scan_if;
    logic       en;
    logic [3:0] hr_h;
    logic [3:0] hr_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic       blank_lz;
    logic       dp_blink;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       frame_done;

    // Timer / control side: drives digits and controls, observes the pins.
    modport master (
        output en, hr_h, hr_l, min_h, min_l, sec_h, sec_l, blank_lz, dp_blink,
        input  seg, dp, dig, frame_done
    );

    // Display driver side.
    modport slave (
        input  en, hr_h, hr_l, min_h, min_l, sec_h, sec_l, blank_lz, dp_blink,
        output seg, dp, dig, frame_done
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Purpose: multiplexes six BCD digits onto one 7-segment bus with a one-hot digit select.
// Latency: all outputs are registered, one cycle behind the internal slot counter.
// Backpressure: none; the digits are sampled once per frame so a mid-frame update never tears.
module bcd_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 50,
    parameter int BLINK_FRAMES = 83,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              Clk,
    input  logic              rst_n,
    bcd_display_scan_if.slave bus
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] GUARD_END  = 16'(GUARD);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
    localparam logic        POL        = (ACTIVE_LOW != 0);

    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [15:0]     blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic [5:0][3:0] shd_q, shd_d;

    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [5:0]      dig_q, dig_d;
    logic            frame_done_q, frame_done_d;

    logic            slot_last;
    logic            frame_start;
    logic            frame_end;
    logic            lit_window;
    logic            blanked;
    logic            sep_slot;
    logic [3:0]      cur_bcd;
    logic [6:0]      cur_pat;

    // Slot counter and digit index; both park at 0 while the display is disabled.
    always_comb begin
        slot_last   = (cnt_q == SCAN_LAST);
        frame_start = bus.en && (cnt_q == 16'd0) && (idx_q == 3'd0);
        frame_end   = bus.en && slot_last && (idx_q == 3'd5);
        lit_window  = bus.en && (cnt_q >= GUARD_END);
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        if (!bus.en) begin
            cnt_d = 16'd0;
            idx_d = 3'd0;
        end else if (slot_last) begin
            cnt_d = 16'd0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Frame-start snapshot of all six digits, and the per-frame blink phase counter.
    always_comb begin
        shd_d       = shd_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_start) begin
            shd_d = {bus.hr_h, bus.hr_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};
        end
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 16'd0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    // Select the shadowed digit for the current slot and apply leading-zero blanking.
    always_comb begin
        cur_bcd = 4'd0;
        case (idx_q)
            3'd0:    cur_bcd = shd_q[0];
            3'd1:    cur_bcd = shd_q[1];
            3'd2:    cur_bcd = shd_q[2];
            3'd3:    cur_bcd = shd_q[3];
            3'd4:    cur_bcd = shd_q[4];
            3'd5:    cur_bcd = shd_q[5];
            default: cur_bcd = 4'd0;
        endcase
        blanked  = bus.blank_lz &&
                   (((idx_q == 3'd5) && (shd_q[5] == 4'd0)) ||
                    ((idx_q == 3'd4) && (shd_q[5] == 4'd0) && (shd_q[4] == 4'd0)));
        sep_slot = (idx_q == 3'd2) || (idx_q == 3'd4);
    end

    // BCD to segments (bit 0 = a .. bit 6 = g); non-decimal codes show a dash.
    always_comb begin
        cur_pat = 7'b1000000;
        case (cur_bcd)
            4'd0:    cur_pat = 7'b0111111;
            4'd1:    cur_pat = 7'b0000110;
            4'd2:    cur_pat = 7'b1011011;
            4'd3:    cur_pat = 7'b1001111;
            4'd4:    cur_pat = 7'b1100110;
            4'd5:    cur_pat = 7'b1101101;
            4'd6:    cur_pat = 7'b1111101;
            4'd7:    cur_pat = 7'b0000111;
            4'd8:    cur_pat = 7'b1111111;
            4'd9:    cur_pat = 7'b1101111;
            default: cur_pat = 7'b1000000;
        endcase
    end

    // Logical output levels, then folded to board polarity before registering.
    always_comb begin
        seg_d        = {7{POL}};
        dig_d        = {6{POL}};
        if (lit_window && !blanked) begin
            seg_d = cur_pat ^ {7{POL}};
            dig_d = 6'(6'd1 << idx_q) ^ {6{POL}};
        end
        dp_d         = (lit_window && sep_slot && (!bus.dp_blink || blink_on_q)) ^ POL;
        frame_done_d = frame_end;
    end

    // Scan state, blink state and digit shadows.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            blink_cnt_q <= 16'd0;
            blink_on_q  <= 1'b1;
            shd_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            shd_q       <= shd_d;
        end
    end

    // Registered pins; reset drives every display line to its dark level.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= {7{POL}};
            dp_q         <= POL;
            dig_q        <= {6{POL}};
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.dig        = dig_q;
    assign bus.frame_done = frame_done_q;

endmodule
